// File: rtl/mem_dump_reader_if.sv
// Memory read port and word stream shared by mem_dump_reader and its neighbours.
// master = the dumper, slave = the mainMem/sink side.
interface mem_dump_reader_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_enable;
  logic              mem_wren;
  logic [1:0]        mem_acc_size;
  logic              mem_busy;
  logic [31:0]       mem_data_out;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output mem_addr, mem_enable, mem_wren, mem_acc_size,
    input  mem_busy, mem_data_out,
    output out_valid, out_data, out_addr, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_enable, mem_wren, mem_acc_size,
    output mem_busy, mem_data_out,
    input  out_valid, out_data, out_addr, out_last,
    output out_ready
  );
endinterface

// File: rtl/mem_dump_reader.sv
// Walks a word range of mainMem and streams each word out with its address.
// Optional running checksum output enabled by defining MEM_DUMP_CHECKSUM_EN.
module mem_dump_reader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
`ifdef MEM_DUMP_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  mem_dump_reader_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } state_t;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic [2:0]        lat_cnt;
  logic              out_valid_q;
  logic [31:0]       out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_last_q;
  logic              error_q;
  logic              start_bad;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0]       checksum_q;
`endif

  // An empty or misaligned request skips straight to DONE without touching memory.
  assign start_bad = (word_count == '0) || (base_addr[1:0] != 2'b00);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = start_bad ? ST_DONE : ST_REQ;
      ST_REQ:  if (!bus.mem_busy) state_next = ST_WAIT;
      ST_WAIT: if (lat_cnt == 3'd1) state_next = ST_OUT;
      ST_OUT:  if (bus.out_ready) state_next = (remaining == CNT_W'(1)) ? ST_DONE : ST_REQ;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: one read in flight at a time, output word held until handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr    <= '0;
      remaining   <= '0;
      lat_cnt     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      error_q     <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            error_q <= (word_count != '0) && (base_addr[1:0] != 2'b00);
`ifdef MEM_DUMP_CHECKSUM_EN
            checksum_q <= '0;
`endif
            if (!start_bad) begin
              cur_addr  <= base_addr;
              remaining <= word_count;
            end
          end
        end
        ST_REQ: begin
          if (!bus.mem_busy) lat_cnt <= RD_LAT_C;
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            out_data_q  <= bus.mem_data_out;
            out_addr_q  <= cur_addr;
            out_valid_q <= 1'b1;
            out_last_q  <= (remaining == CNT_W'(1));
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            cur_addr    <= cur_addr + ADDR_W'(4);
            remaining   <= remaining - CNT_W'(1);
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            checksum_q  <= {checksum_q[30:0], checksum_q[31]} ^ out_data_q;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);
  assign error = error_q;

  assign bus.mem_enable   = (state == ST_REQ);
  assign bus.mem_addr     = (state == ST_REQ) ? cur_addr : '0;
  assign bus.mem_wren     = 1'b0;
  assign bus.mem_acc_size = 2'b00;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_addr     = out_addr_q;
  assign bus.out_last     = out_last_q;

`ifdef MEM_DUMP_CHECKSUM_EN
  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: stimulus pushes expected words, a
// negedge monitor compares every presented word against the queue head.
module tb_mem_dump_reader;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        error;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  mem_dump_reader_if #(.ADDR_W(32)) bus ();

  mem_dump_reader #(.ADDR_W(32), .CNT_W(16), .RD_LAT(1)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
`ifdef MEM_DUMP_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .bus        (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   read_cnt = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  bit   expect_done = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hand-written memory image; anything else reads as a poison value.
  function automatic logic [31:0] mem_lookup(input logic [31:0] addr);
    case (addr)
      32'h8002_0000: return 32'h1111_1111;
      32'h8002_0004: return 32'h2222_2222;
      32'h8002_0008: return 32'h3333_3333;
      32'hFFFF_FFF8: return 32'hDEAD_0001;
      32'hFFFF_FFFC: return 32'hDEAD_0002;
      32'h0000_0000: return 32'hDEAD_0003;
      32'h0000_0100: return 32'h0000_0001;
      32'h0000_0104: return 32'h8000_0000;
      default:       return 32'hBAD0_BAD0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (bus.mem_enable && !bus.mem_busy) bus.mem_data_out <= mem_lookup(bus.mem_addr);
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] addr, input logic [31:0] data, input logic last);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [31:0] base, input logic [15:0] count);
    start      = 1'b1;
    base_addr  = base;
    word_count = count;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    bit found = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (done) begin
        found = 1;
        break;
      end
    end
    check_output({name, "_done_seen"}, 32'(found), 32'd1);
    tick();
  endtask

  task automatic wait_second_word(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (hs_cnt == 1 && bus.out_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    check_output("word2_reached", 32'(ok), 32'd1);
  endtask

  // Monitor: compares the presented word with the queue head every cycle it is valid,
  // so a word that changes under backpressure is caught as well.
  always @(negedge clock) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (expect_done) begin
        check_output("done_after_last", 32'(done), 32'd1);
        expect_done = 0;
      end
      if (bus.mem_enable && !bus.mem_busy) read_cnt++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_word", bus.out_addr, 32'hFFFF_FFFF);
        end else begin
          check_output("out_data", bus.out_data, exp_q[0].data);
          check_output("out_addr", bus.out_addr, exp_q[0].addr);
          check_output("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
          if (bus.out_ready) begin
            if (exp_q[0].last) expect_done = 1;
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int done_snap;
    reset_n       = 1'b0;
    start         = 1'b0;
    base_addr     = '0;
    word_count    = '0;
    bus.mem_busy  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    check_output("rst_busy",     32'(busy), 32'd0);
    check_output("rst_done",     32'(done), 32'd0);
    check_output("rst_error",    32'(error), 32'd0);
    check_output("rst_valid",    32'(bus.out_valid), 32'd0);
    check_output("rst_last",     32'(bus.out_last), 32'd0);
    check_output("rst_enable",   32'(bus.mem_enable), 32'd0);
    check_output("rst_mem_addr", bus.mem_addr, 32'd0);
    check_output("rst_out_data", bus.out_data, 32'd0);
    check_output("rst_out_addr", bus.out_addr, 32'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] basic three-word dump");
    bus.out_ready = 1'b1;
    read_cnt = 0;
    push_word(32'h8002_0000, 32'h1111_1111, 1'b0);
    push_word(32'h8002_0004, 32'h2222_2222, 1'b0);
    push_word(32'h8002_0008, 32'h3333_3333, 1'b1);
    apply_stimulus(32'h8002_0000, 16'd3);
    check_output("basic_busy", 32'(busy), 32'd1);
    wait_done("basic", 60);
    check_output("basic_queue_empty", 32'(exp_q.size()), 32'd0);
    check_output("basic_reads", 32'(read_cnt), 32'd3);
    check_output("basic_busy_after", 32'(busy), 32'd0);

    $display("[TB] backpressure on word 2");
    read_cnt = 0;
    hs_cnt = 0;
    push_word(32'h8002_0000, 32'h1111_1111, 1'b0);
    push_word(32'h8002_0004, 32'h2222_2222, 1'b0);
    push_word(32'h8002_0008, 32'h3333_3333, 1'b1);
    apply_stimulus(32'h8002_0000, 16'd3);
    wait_second_word(ok);
    bus.out_ready = 1'b0;
    repeat (5) tick();
    check_output("bp_reads_held", 32'(read_cnt), 32'd2);
    bus.out_ready = 1'b1;
    wait_done("bp", 60);
    check_output("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    check_output("bp_reads", 32'(read_cnt), 32'd3);

    $display("[TB] mem_busy stall on first request");
    read_cnt = 0;
    bus.mem_busy = 1'b1;
    push_word(32'h8002_0000, 32'h1111_1111, 1'b0);
    push_word(32'h8002_0004, 32'h2222_2222, 1'b0);
    push_word(32'h8002_0008, 32'h3333_3333, 1'b1);
    apply_stimulus(32'h8002_0000, 16'd3);
    for (int i = 0; i < 3; i++) begin
      check_output("stall_enable", 32'(bus.mem_enable), 32'd1);
      check_output("stall_addr", bus.mem_addr, 32'h8002_0000);
      if (i < 2) tick();
    end
    bus.mem_busy = 1'b0;
    wait_done("stall", 60);
    check_output("stall_reads", 32'(read_cnt), 32'd3);

    $display("[TB] zero-length dump");
    read_cnt = 0;
    apply_stimulus(32'h8002_0000, 16'd0);
    wait_done("zero", 5);
    check_output("zero_reads", 32'(read_cnt), 32'd0);
    check_output("zero_error", 32'(error), 32'd0);

    $display("[TB] misaligned base");
    apply_stimulus(32'h8002_0002, 16'd2);
    wait_done("unaligned", 5);
    check_output("unaligned_error", 32'(error), 32'd1);
    check_output("unaligned_reads", 32'(read_cnt), 32'd0);
    push_word(32'h8002_0000, 32'h1111_1111, 1'b1);
    apply_stimulus(32'h8002_0000, 16'd1);
    check_output("error_cleared", 32'(error), 32'd0);
    wait_done("after_error", 30);

    $display("[TB] address wrap with ignored start");
    push_word(32'hFFFF_FFF8, 32'hDEAD_0001, 1'b0);
    push_word(32'hFFFF_FFFC, 32'hDEAD_0002, 1'b0);
    push_word(32'h0000_0000, 32'hDEAD_0003, 1'b1);
    apply_stimulus(32'hFFFF_FFF8, 16'd3);
    tick();
    apply_stimulus(32'h8002_0000, 16'd1);
    wait_done("wrap", 60);
    check_output("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
    check_output("wrap_error", 32'(error), 32'd0);

    $display("[TB] two-word checksum dump");
    push_word(32'h0000_0100, 32'h0000_0001, 1'b0);
    push_word(32'h0000_0104, 32'h8000_0000, 1'b1);
    apply_stimulus(32'h0000_0100, 16'd2);
    wait_done("cksum", 40);
`ifdef MEM_DUMP_CHECKSUM_EN
    check_output("checksum", checksum, 32'h8000_0002);
`endif
    check_output("cksum_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] reset in the middle of word 2");
    hs_cnt = 0;
    push_word(32'h8002_0000, 32'h1111_1111, 1'b0);
    push_word(32'h8002_0004, 32'h2222_2222, 1'b0);
    push_word(32'h8002_0008, 32'h3333_3333, 1'b1);
    apply_stimulus(32'h8002_0000, 16'd3);
    wait_second_word(ok);
    bus.out_ready = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_output("abort_valid", 32'(bus.out_valid), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    expect_done = 0;
    done_snap = done_cnt;
    repeat (2) tick();
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (8) tick();
    check_output("abort_no_done", 32'(done_cnt), 32'(done_snap));
    check_output("abort_idle_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
